// File: rtl/weight_store_pkg.sv
// Shared defaults and FSM state type for the weight store slice.
// The store feeds the weight_updater w port and commits its result port.
package weight_store_pkg;

  localparam int DEF_NEURON_NUM        = 5;
  localparam int DEF_WEIGHT_CELL_WIDTH = 16;
  localparam int DEF_LAYER_MAX         = 4;
  localparam int DEF_LAYER_ADDR_WIDTH  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    WAIT_UPD = 2'd2
  } state_t;

endpackage

// File: rtl/weight_store_regfile.sv
// LAYER_MAX rows of whole-matrix registers.
// One synchronous write port, one registered read port, synchronous clear.
module weight_store_regfile #(
  parameter int LAYER_MAX        = 4,
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int MAT_WIDTH        = 400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [LAYER_ADDR_WIDTH-1:0] waddr,
  input  logic [MAT_WIDTH-1:0]        wdata,
  input  logic                        re,
  input  logic [LAYER_ADDR_WIDTH-1:0] raddr,
  output logic [MAT_WIDTH-1:0]        rdata
);

  logic [MAT_WIDTH-1:0] mem [LAYER_MAX];
  logic [MAT_WIDTH-1:0] rmux;

  // An address with no matching row reads as all zeros.
  always_comb begin
    rmux = '0;
    for (int i = 0; i < LAYER_MAX; i++) begin
      if (raddr == LAYER_ADDR_WIDTH'(i)) rmux = mem[i];
    end
  end

  // NOTE: the array is cleared by rst because reset must zero every stored weight;
  // this forces flops rather than a RAM macro, which is acceptable at these depths.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAYER_MAX; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      for (int i = 0; i < LAYER_MAX; i++) begin
        if (we && waddr == LAYER_ADDR_WIDTH'(i)) mem[i] <= wdata;
      end
      if (re) rdata <= rmux;
    end
  end

endmodule

// File: rtl/weight_store.sv
// Weight matrix store: serves a layer's matrix on w, then commits the updated one from upd.
// Preload port writes matrices while idle; out-of-range layers set a sticky error.
module weight_store
  import weight_store_pkg::*;
#(
  parameter int  NEURON_NUM        = DEF_NEURON_NUM,
  parameter int  WEIGHT_CELL_WIDTH = DEF_WEIGHT_CELL_WIDTH,
  parameter int  LAYER_MAX         = DEF_LAYER_MAX,
  parameter int  LAYER_ADDR_WIDTH  = DEF_LAYER_ADDR_WIDTH,
  localparam int MAT               = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LAYER_ADDR_WIDTH-1:0] req_layer,
  input  logic                        req_valid,
  output logic                        req_ready,
  output logic [MAT-1:0]              w,
  output logic                        w_valid,
  input  logic                        w_ready,
  input  logic [MAT-1:0]              upd,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0] load_layer,
  input  logic [MAT-1:0]              load_data,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic                        busy,
  output logic                        error
);

  state_t                      state, state_nxt;
  logic [LAYER_ADDR_WIDTH-1:0] cur_layer;
  logic                        cur_ok;
  logic                        req_ok, load_ok;
  logic                        req_fire, load_fire, w_fire, upd_fire;
  logic                        rf_we;
  logic [LAYER_ADDR_WIDTH-1:0] rf_waddr;
  logic [MAT-1:0]              rf_wdata;

  assign req_ok  = int'(req_layer) < LAYER_MAX;
  assign load_ok = int'(load_layer) < LAYER_MAX;

  // Handshake outputs decode the state register; rst masks them in the cycle it is seen.
  // A pending load takes priority, so req_ready yields to load_valid.
  assign load_ready = (state == IDLE) && !rst;
  assign req_ready  = (state == IDLE) && !rst && !load_valid;
  assign w_valid    = (state == SERVE) && !rst;
  assign upd_ready  = (state == WAIT_UPD) && !rst;
  assign busy       = (state != IDLE);

  assign load_fire = load_valid && load_ready;
  assign req_fire  = req_valid && req_ready;
  assign w_fire    = w_valid && w_ready;
  assign upd_fire  = upd_valid && upd_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (req_fire) state_nxt = SERVE;
      SERVE:    if (w_fire)   state_nxt = WAIT_UPD;
      WAIT_UPD: if (upd_fire) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_layer <= '0;
      cur_ok    <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        cur_layer <= req_layer;
        cur_ok    <= req_ok;
      end
      if ((req_fire && !req_ok) || (load_fire && !load_ok)) error <= 1'b1;
    end
  end

  // Load and upd transfers are mutually exclusive by state, so a plain mux suffices.
  assign rf_we    = (load_fire && load_ok) || (upd_fire && cur_ok);
  assign rf_waddr = upd_fire ? cur_layer : load_layer;
  assign rf_wdata = upd_fire ? upd : load_data;

  weight_store_regfile #(
    .LAYER_MAX        (LAYER_MAX),
    .LAYER_ADDR_WIDTH (LAYER_ADDR_WIDTH),
    .MAT_WIDTH        (MAT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .re    (req_fire),
    .raddr (req_layer),
    .rdata (w)
  );

endmodule
